// File: rtl/block_memory.sv
// Multi-cycle main memory behind the data cache: block fills, strobed word writes and
// block write-backs, one request in flight. Define MEM_WRITE_BUFFER_EN for a posted word-write buffer.
module block_memory #(
  parameter int ROWS          = 64,
  parameter int BLOCK_SIZE    = 4,
  parameter int READ_LATENCY  = 20,
  parameter int WRITE_LATENCY = 20
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [31:0]               Address,
  input  logic                      ReadMiss,
  input  logic                      MemWriteThrough,
  input  logic [31:0]               Write_data,
  input  logic [3:0]                Write_strobe,
  input  logic                      WriteBack,
  input  logic [31:0]               WriteBack_address,
  input  logic [32*BLOCK_SIZE-1:0]  WriteBack_data,
  output logic [32*BLOCK_SIZE-1:0]  Read_data,
  output logic                      ReadReady,
  output logic                      WriteReady,
  output logic                      Busy
);

  localparam int AW      = $clog2(ROWS);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = $clog2(MAX_LAT) + 1;
  localparam logic [CW-1:0] RD_LAST  = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WRITE_LATENCY - 1);
  localparam logic [AW-1:0] BLK_MASK = AW'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, WRITEBACK, READING, WRITING, READ_READY, WRITE_READY
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [31:0]               mem_q [ROWS];
  logic [31:0]               mem_d [ROWS];
  logic [32*BLOCK_SIZE-1:0]  rdata_q, rdata_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [AW-1:0]             wb_base_q, wb_base_d;
  logic [32*BLOCK_SIZE-1:0]  wb_data_q, wb_data_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                strb_q, strb_d;
  logic                      fill_q, fill_d;
  logic                      store_q, store_d;
`ifdef MEM_WRITE_BUFFER_EN
  logic                      posted_q, posted_d;
`endif

  logic addr_unused;
  assign addr_unused = ^{Address[31:AW+2], Address[1:0],
                         WriteBack_address[31:AW+2], WriteBack_address[1:0]};

  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    mem_d     = mem_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    wb_base_d = wb_base_q;
    wb_data_d = wb_data_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    fill_d    = fill_q;
    store_d   = store_q;
`ifdef MEM_WRITE_BUFFER_EN
    posted_d  = posted_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Fields are re-captured every idle cycle; the last capture is the accepted one.
        cnt_d     = '0;
        idx_d     = Address[AW+1:2];
        wb_base_d = WriteBack_address[AW+1:2] & ~BLK_MASK;
        wb_data_d = WriteBack_data;
        wdata_d   = Write_data;
        strb_d    = Write_strobe;
        fill_d    = ReadMiss;
        store_d   = ReadMiss & MemWriteThrough;
        if (WriteBack)            state_d = WRITEBACK;
        else if (ReadMiss)        state_d = READING;
        else if (MemWriteThrough) begin
          state_d = WRITING;
`ifdef MEM_WRITE_BUFFER_EN
          posted_d = 1'b1;
`endif
        end
      end
      WRITEBACK: if (cnt_q == WR_LAST) begin
        for (int i = 0; i < BLOCK_SIZE; i++)
          mem_d[wb_base_q | AW'(i)] = wb_data_q[32*i +: 32];
        cnt_d   = '0;
        state_d = fill_q ? READING : WRITE_READY;
      end
      READING: if (cnt_q == RD_LAST) begin
        // Fill returns the pre-write block; a store miss lands in the same edge.
        for (int i = 0; i < BLOCK_SIZE; i++)
          rdata_d[32*i +: 32] = mem_q[(idx_q & ~BLK_MASK) | AW'(i)];
        if (store_q) mem_d[idx_q] = merge_word(mem_q[idx_q], wdata_q, strb_q);
        state_d = READ_READY;
      end
      WRITING: if (cnt_q == WR_LAST) begin
        mem_d[idx_q] = merge_word(mem_q[idx_q], wdata_q, strb_q);
`ifdef MEM_WRITE_BUFFER_EN
        state_d  = posted_q ? IDLE : WRITE_READY;
        posted_d = 1'b0;
`else
        state_d  = WRITE_READY;
`endif
      end
      READ_READY, WRITE_READY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      idx_q     <= '0;
      wb_base_q <= '0;
      wb_data_q <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      fill_q    <= 1'b0;
      store_q   <= 1'b0;
`ifdef MEM_WRITE_BUFFER_EN
      posted_q  <= 1'b0;
`endif
      // NOTE: the array is reset because contents must read as zero after reset; this forces flops, not RAM.
      for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      idx_q     <= idx_d;
      wb_base_q <= wb_base_d;
      wb_data_q <= wb_data_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      fill_q    <= fill_d;
      store_q   <= store_d;
`ifdef MEM_WRITE_BUFFER_EN
      posted_q  <= posted_d;
`endif
      mem_q     <= mem_d;
    end
  end

  assign Read_data = rdata_q;
  assign ReadReady = (state_q == READ_READY);
  assign Busy      = (state_q != IDLE);
`ifdef MEM_WRITE_BUFFER_EN
  assign WriteReady = (state_q == WRITE_READY) ||
                      (posted_q && state_q == WRITING && cnt_q == CW'(1));
`else
  assign WriteReady = (state_q == WRITE_READY);
`endif

endmodule

// File: tb/tb_block_memory.sv
// Directed self-checking bench for block_memory at default parameters.
// Word-write timing expectations follow MEM_WRITE_BUFFER_EN when it is defined.
module tb_block_memory;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [31:0]  Address, Write_data, WriteBack_address;
  logic         ReadMiss, MemWriteThrough, WriteBack;
  logic [3:0]   Write_strobe;
  logic [127:0] WriteBack_data, Read_data;
  logic         ReadReady, WriteReady, Busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MEM_WRITE_BUFFER_EN
  localparam int WR_AT   = 1;
  localparam int WR_IDLE = 20;
`else
  localparam int WR_AT   = 20;
  localparam int WR_IDLE = 21;
`endif

  block_memory dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .ReadMiss(ReadMiss),
    .MemWriteThrough(MemWriteThrough), .Write_data(Write_data),
    .Write_strobe(Write_strobe), .WriteBack(WriteBack),
    .WriteBack_address(WriteBack_address), .WriteBack_data(WriteBack_data),
    .Read_data(Read_data), .ReadReady(ReadReady), .WriteReady(WriteReady), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic clear_inputs();
    Address = '0; ReadMiss = 0; MemWriteThrough = 0; Write_data = '0;
    Write_strobe = '0; WriteBack = 0; WriteBack_address = '0; WriteBack_data = '0;
  endtask

  // Drives one request for one edge, then watches up to 200 edges until Busy drops.
  // k counts edges after the acceptance edge; outputs are sampled on the falling edge.
  // At edge number intrude a word write is injected for one cycle and must be ignored.
  task automatic run_txn(input logic rm, input logic wt, input logic wb,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] wba,
                         input logic [127:0] wbd, input int intrude,
                         output int busy0, output int rr_at, output int wr_at,
                         output int idle_at, output int rr_n, output int wr_n,
                         output logic [127:0] rdata);
    rr_at = -1; wr_at = -1; idle_at = -1; rr_n = 0; wr_n = 0; rdata = '0;
    @(negedge Clk);
    ReadMiss = rm; MemWriteThrough = wt; WriteBack = wb; Address = addr;
    Write_data = wdata; Write_strobe = strb; WriteBack_address = wba; WriteBack_data = wbd;
    @(posedge Clk);
    @(negedge Clk);
    clear_inputs();
    busy0 = int'(Busy);
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (ReadReady) begin
        rr_n++;
        if (rr_at < 0) begin rr_at = k; rdata = Read_data; end
      end
      if (WriteReady) begin
        wr_n++;
        if (wr_at < 0) wr_at = k;
      end
      if (k == intrude) begin
        MemWriteThrough = 1; Address = addr; Write_data = 32'hFFFF_FFFF; Write_strobe = 4'hF;
      end else if (k == intrude + 1) begin
        clear_inputs();
      end
      if (!Busy) begin idle_at = k; break; end
    end
    clear_inputs();
    if (idle_at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: Busy still %0d after 200 edges, want 0", Busy);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [127:0] rdata, output int rr_at);
    int b0, wa, ia, rn, wn;
    run_txn(1, 0, 0, addr, '0, '0, '0, '0, -1, b0, rr_at, wa, ia, rn, wn, rdata);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output int wr_at, output int idle_at);
    int b0, ra, rn, wn;
    logic [127:0] d;
    run_txn(0, 1, 0, addr, wdata, strb, '0, '0, -1, b0, ra, wr_at, idle_at, rn, wn, d);
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst = 0;
    repeat (3) @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0 || ReadReady !== 1'b0 || WriteReady !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: busy=%b rr=%b wr=%b want 0 0 0", Busy, ReadReady, WriteReady); end
    n_cmp++; if (Read_data !== 128'h0) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0", Read_data); end
    Rst = 1;
    @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_read_after_reset();
    int b0, ra, wa, ia, rn, wn;
    logic [127:0] d;
    run_txn(1, 0, 0, 32'h0, '0, '0, '0, '0, -1, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (b0 !== 1) begin n_bad++; $display("FAIL read0_busy_rise: got %0d want 1", b0); end
    n_cmp++; if (ra !== 20) begin n_bad++; $display("FAIL read0_latency: got %0d want 20", ra); end
    n_cmp++; if (ia !== 21) begin n_bad++; $display("FAIL read0_busy_fall: got %0d want 21", ia); end
    n_cmp++; if (d !== 128'h0) begin n_bad++; $display("FAIL read0_data: got %h want 0", d); end
    n_cmp++; if (rn !== 1 || wn !== 0) begin
      n_bad++; $display("FAIL read0_pulses: rr=%0d wr=%0d want 1 0", rn, wn); end
  endtask

  task automatic test_word_write();
    int wa, ia, ra;
    logic [127:0] d;
    do_write(32'h14, 32'hDEAD_BEEF, 4'hF, wa, ia);
    n_cmp++; if (wa !== WR_AT) begin n_bad++; $display("FAIL write_latency: got %0d want %0d", wa, WR_AT); end
    n_cmp++; if (ia !== WR_IDLE) begin n_bad++; $display("FAIL write_busy_fall: got %0d want %0d", ia, WR_IDLE); end
    do_read(32'h10, d, ra);
    n_cmp++; if (d !== 128'h00000000_00000000_DEADBEEF_00000000) begin
      n_bad++; $display("FAIL write_readback: got %h want 00000000_00000000_deadbeef_00000000", d); end
    @(negedge Clk);
    n_cmp++; if (Read_data !== 128'h00000000_00000000_DEADBEEF_00000000) begin
      n_bad++; $display("FAIL rdata_hold: got %h want 00000000_00000000_deadbeef_00000000", Read_data); end
  endtask

  task automatic test_strobe();
    int wa, ia, ra;
    logic [127:0] d;
    do_write(32'h14, 32'h1234_ABCD, 4'b0011, wa, ia);
    do_read(32'h10, d, ra);
    n_cmp++; if (d !== 128'h00000000_00000000_DEADABCD_00000000) begin
      n_bad++; $display("FAIL strobe_merge: got %h want 00000000_00000000_deadabcd_00000000", d); end
  endtask

  task automatic test_store_miss();
    int b0, ra, wa, ia, rn, wn;
    logic [127:0] d;
    run_txn(1, 1, 0, 32'h18, 32'h0000_0055, 4'hF, '0, '0, -1, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (ra !== 20) begin n_bad++; $display("FAIL store_miss_latency: got %0d want 20", ra); end
    n_cmp++; if (d !== 128'h00000000_00000000_DEADABCD_00000000) begin
      n_bad++; $display("FAIL store_miss_prewrite: got %h want 00000000_00000000_deadabcd_00000000", d); end
    n_cmp++; if (rn !== 1 || wn !== 0) begin
      n_bad++; $display("FAIL store_miss_pulses: rr=%0d wr=%0d want 1 0", rn, wn); end
    do_read(32'h10, d, ra);
    n_cmp++; if (d !== 128'h00000000_00000055_DEADABCD_00000000) begin
      n_bad++; $display("FAIL store_miss_written: got %h want 00000000_00000055_deadabcd_00000000", d); end
  endtask

  task automatic test_wrap();
    int wa, ia, ra;
    logic [127:0] d;
    do_write(32'h114, 32'h0BAD_CAFE, 4'hF, wa, ia);
    do_read(32'h10, d, ra);
    n_cmp++; if (d !== 128'h00000000_00000055_0BADCAFE_00000000) begin
      n_bad++; $display("FAIL addr_wrap: got %h want 00000000_00000055_0badcafe_00000000", d); end
  endtask

  task automatic test_writeback_fill();
    int b0, ra, wa, ia, rn, wn;
    logic [127:0] d;
    run_txn(1, 0, 1, 32'h80, '0, '0, 32'h40, 128'h00000004_00000003_00000002_00000001,
            -1, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (ra !== 40) begin n_bad++; $display("FAIL wb_fill_latency: got %0d want 40", ra); end
    n_cmp++; if (d !== 128'h0) begin n_bad++; $display("FAIL wb_fill_data: got %h want 0", d); end
    n_cmp++; if (wn !== 0) begin n_bad++; $display("FAIL wb_fill_no_wready: got %0d want 0", wn); end
    do_read(32'h40, d, ra);
    n_cmp++; if (d !== 128'h00000004_00000003_00000002_00000001) begin
      n_bad++; $display("FAIL wb_victim_readback: got %h want 00000004_00000003_00000002_00000001", d); end
    run_txn(1, 0, 1, 32'h64, '0, '0, 32'h60, 128'h00000008_00000007_00000006_00000005,
            -1, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (d !== 128'h00000008_00000007_00000006_00000005) begin
      n_bad++; $display("FAIL wb_fill_same_block: got %h want 00000008_00000007_00000006_00000005", d); end
  endtask

  task automatic test_writeback_only();
    int b0, ra, wa, ia, rn, wn;
    logic [127:0] d;
    run_txn(0, 0, 1, '0, '0, '0, 32'hC4, 128'h0000000D_0000000C_0000000B_0000000A,
            -1, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (wa !== 20) begin n_bad++; $display("FAIL wb_only_latency: got %0d want 20", wa); end
    n_cmp++; if (rn !== 0 || ia !== 21) begin
      n_bad++; $display("FAIL wb_only_end: rr=%0d idle=%0d want 0 21", rn, ia); end
    do_read(32'hC0, d, ra);
    n_cmp++; if (d !== 128'h0000000D_0000000C_0000000B_0000000A) begin
      n_bad++; $display("FAIL wb_only_readback: got %h want 0000000d_0000000c_0000000b_0000000a", d); end
  endtask

  task automatic test_back_to_back();
    int b0, ra, wa, ia, rn, wn;
    logic [127:0] d;
    run_txn(1, 0, 0, 32'h20, '0, '0, '0, '0, 5, b0, ra, wa, ia, rn, wn, d);
    n_cmp++; if (ra !== 20 || wn !== 0) begin
      n_bad++; $display("FAIL busy_ignore_timing: rr_at=%0d wr=%0d want 20 0", ra, wn); end
    do_read(32'h20, d, ra);
    n_cmp++; if (d !== 128'h0 || ra !== 20) begin
      n_bad++; $display("FAIL busy_ignore_data: got %h at %0d want 0 at 20", d, ra); end
  endtask

  task automatic test_reset_abort();
    int wr_n, ra;
    logic [127:0] d;
    @(negedge Clk);
    MemWriteThrough = 1; Address = 32'h14; Write_data = 32'h7777_7777; Write_strobe = 4'hF;
    @(posedge Clk);
    @(negedge Clk);
    clear_inputs();
    repeat (10) @(negedge Clk);
    Rst = 0;
    repeat (2) @(negedge Clk);
    n_cmp++; if (Busy !== 1'b0 || Read_data !== 128'h0) begin
      n_bad++; $display("FAIL abort_reset_state: busy=%b rdata=%h want 0 0", Busy, Read_data); end
    Rst = 1;
    wr_n = 0;
    repeat (30) begin
      @(negedge Clk);
      if (WriteReady || Busy) wr_n++;
    end
    n_cmp++; if (wr_n !== 0) begin n_bad++; $display("FAIL abort_no_ready: got %0d active cycles want 0", wr_n); end
    do_read(32'h10, d, ra);
    n_cmp++; if (d !== 128'h0) begin n_bad++; $display("FAIL abort_no_write: got %h want 0", d); end
  endtask

`ifdef MEM_WRITE_BUFFER_EN
  task automatic test_write_buffer();
    int rr_n, idle_at, ra;
    logic [127:0] d;
    @(negedge Clk);
    MemWriteThrough = 1; Address = 32'h08; Write_data = 32'hCAFE_F00D; Write_strobe = 4'hF;
    @(posedge Clk);
    @(negedge Clk);
    clear_inputs();
    @(posedge Clk);
    @(negedge Clk);
    n_cmp++; if (WriteReady !== 1'b1) begin n_bad++; $display("FAIL buf_wready: got %b want 1", WriteReady); end
    ReadMiss = 1; Address = 32'h0;
    @(posedge Clk);
    @(negedge Clk);
    clear_inputs();
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL buf_busy: got %b want 1", Busy); end
    rr_n = 0; idle_at = -1;
    for (int k = 3; k <= 60; k++) begin
      if (ReadReady) rr_n++;
      if (!Busy) begin idle_at = k; break; end
      @(negedge Clk);
    end
    n_cmp++; if (rr_n !== 0 || idle_at < 0) begin
      n_bad++; $display("FAIL buf_ignore: rr=%0d idle=%0d want 0 and drained", rr_n, idle_at); end
    do_read(32'h0, d, ra);
    n_cmp++; if (d !== 128'h00000000_CAFEF00D_00000000_00000000) begin
      n_bad++; $display("FAIL buf_drain_data: got %h want 00000000_cafef00d_00000000_00000000", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_after_reset();
    test_word_write();
    test_strobe();
    test_store_miss();
    test_wrap();
    test_writeback_fill();
    test_writeback_only();
    test_back_to_back();
    test_reset_abort();
`ifdef MEM_WRITE_BUFFER_EN
    test_write_buffer();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_memory.md
# block_memory

Parametrised multi-cycle main memory behind the data cache; successor to the fixed 64-word, 4-word-block, 20-cycle memory. Serves block fills on read misses, word write-throughs with byte strobes, and full-block write-backs of dirty victims. Latencies, depth and block size are parameters. A single request is in flight at a time, tracked by a Busy/Ready handshake.

## Interface
- ROWS, 64: memory depth in 32-bit words; power of two.
- BLOCK_SIZE, 4: words per block; power of two, ≤ ROWS.
- READ_LATENCY, 20: cycles from request acceptance to ReadReady; ≥ 2.
- WRITE_LATENCY, 20: cycles from acceptance to WriteReady, also the duration of a block write-back; ≥ 2.

- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Address  in  32  byte address for read miss / word write.
- ReadMiss  in  1  block fill request.
- MemWriteThrough  in  1  word write request.
- Write_data  in  32  word write data.
- Write_strobe  in  4  byte enables for the word write; bit n enables byte n.
- WriteBack  in  1  dirty block write-back request.
- WriteBack_address  in  32  victim block address.
- WriteBack_data  in  32*BLOCK_SIZE  victim block; word i at [32i+31:32i].
- Read_data  out  32*BLOCK_SIZE  filled block; word i at [32i+31:32i].
- ReadReady  out  1  one-cycle pulse; Read_data is valid.
- WriteReady  out  1  one-cycle pulse; the write has completed.
- Busy  out  1  request in progress; new requests are ignored.

## Operation
- States: IDLE, WRITEBACK, READING, WRITING, READ_READY, WRITE_READY.
- Requests are sampled only in IDLE. All request fields (Address, data, strobes, victim) are captured at acceptance.
- Word index is Address[log2(ROWS)+1:2]. Upper bits are ignored, so addresses wrap modulo ROWS words. Address[1:0] is ignored.
- Block base is the word index with its low log2(BLOCK_SIZE) bits cleared.
- Request priority when several requests are asserted together:
  - WriteBack: enter WRITEBACK. If ReadMiss is also set, continue to READING; otherwise finish with WRITE_READY.
  - ReadMiss: enter READING.
  - MemWriteThrough alone: enter WRITING.
- ReadMiss together with MemWriteThrough (store miss):
  - Read_data returns the pre-write block.
  - The strobed word is written at read completion.
  - Only ReadReady pulses.
- WRITEBACK writes all BLOCK_SIZE words in its final cycle.
- READ_READY and WRITE_READY each last one cycle, then return to IDLE.
- Read_data holds its value until the next fill completes.
- Busy = 1 in every state except IDLE.
- Reset: state IDLE, counter 0, Read_data 0, all outputs 0, memory cleared to 0.
- Reset mid-operation aborts the request. No memory update is performed and no Ready pulse is generated.

## Timing
- Request accepted at edge T; Busy rises after T.
- Read: ReadReady is high in the cycle after edge T+READ_LATENCY. Busy falls after edge T+READ_LATENCY+1.
- Word write: WriteReady is high after edge T+WRITE_LATENCY.
- Write-back only: WriteReady is high after edge T+WRITE_LATENCY.
- Write-back plus fill: ReadReady is high after edge T+WRITE_LATENCY+READ_LATENCY. The fill observes the written-back data when both target the same block.
- Latency counter width is $clog2(max(READ_LATENCY, WRITE_LATENCY))+1. The counter saturates, never wraps.

## Configuration
- MEM_WRITE_BUFFER_EN defined: adds a one-entry posted write buffer for MemWriteThrough-only requests.
  - WriteReady pulses after edge T+1.
  - The buffer drains in the background over WRITE_LATENCY cycles.
  - Busy = 1 while draining. Any request made during the drain is ignored until the drain finishes.
  - A read accepted after the drain sees the buffered data.
- MEM_WRITE_BUFFER_EN undefined: word-write timing is exactly as in ## Timing, with no buffer logic.

## Test plan
All scenarios use default parameters.
- Rst low then high; ReadMiss at 0x00 -> ReadReady after edge 20, Read_data = 0, Busy low after edge 21.
- Write 0xDEADBEEF to 0x14 with strobe 4'hF -> WriteReady after edge 20. Then read 0x10 -> Read_data[63:32] = 0xDEADBEEF, other words 0.
- Write 0x1234ABCD to 0x14 with strobe 4'b0011 -> word at 0x14 reads 0xDEADABCD.
- WriteBack of victim 0x40 (words 1,2,3,4) together with ReadMiss at 0x80:
  - ReadReady after edge 40; a subsequent read of 0x40 returns {4,3,2,1}.
- Address 0x114 aliases to 0x14 (wrap). Rst pulsed low at cycle 10 of a write -> no WriteReady, memory unchanged.
- With MEM_WRITE_BUFFER_EN: write 0xCAFEF00D to 0x08 -> WriteReady after edge 1. A ReadMiss at edge 2 is ignored (Busy = 1). Reissued after the drain, it returns 0xCAFEF00D in word 2.
